axi4_memory_controller: RTL and testbench

AXI4 master that turns simple user burst requests (start pulse, address, beat count) into AXI4 INCR write and read bursts toward a memory slave. It sits between an internal requester and an AXI4 memory/interconnect. It has one shared FSM, so only one burst is outstanding at a time.

---
 rtl/axi4_memory_controller.sv | 215 +++++++++++++++++++++
 tb/tb_axi4_memory_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_memory_controller.sv
// AXI4 master that turns start-pulse/address/length user requests into single
// outstanding INCR write and read bursts; one shared FSM serves both directions.
module axi4_memory_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [7:0]            write_len,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_data_ack,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [7:0]            read_len,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_valid,
  output logic                  write_done,
  output logic                  read_done,
  output logic [1:0]            resp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA
  } state_t;

  state_t                r_state;
  logic                  r_start_write_d, r_start_read_d;
  logic                  r_wr_pend, r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
  logic [7:0]            r_wr_len, r_rd_len;
  logic [7:0]            r_beat;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [7:0]            r_awlen, r_arlen;
  logic                  r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_data_valid, r_write_done, r_read_done;
  logic [1:0]            r_resp;

  logic w_wr_edge, w_rd_edge;

  assign w_wr_edge = start_write & ~r_start_write_d;
  assign w_rd_edge = start_read & ~r_start_read_d;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state           <= S_IDLE;
      r_start_write_d   <= 1'b0;
      r_start_read_d    <= 1'b0;
      r_wr_pend         <= 1'b0;
      r_rd_pend         <= 1'b0;
      r_wr_addr         <= '0;
      r_rd_addr         <= '0;
      r_wr_len          <= '0;
      r_rd_len          <= '0;
      r_beat            <= '0;
      r_awaddr          <= '0;
      r_araddr          <= '0;
      r_awlen           <= '0;
      r_arlen           <= '0;
      r_awvalid         <= 1'b0;
      r_wvalid          <= 1'b0;
      r_wlast           <= 1'b0;
      r_bready          <= 1'b0;
      r_arvalid         <= 1'b0;
      r_rready          <= 1'b0;
      r_read_data       <= '0;
      r_read_data_valid <= 1'b0;
      r_write_done      <= 1'b0;
      r_read_done       <= 1'b0;
      r_resp            <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees pre-edge state.
      r_start_write_d   <= start_write;
      r_start_read_d    <= start_read;
      r_write_done      <= 1'b0;
      r_read_done       <= 1'b0;
      r_read_data_valid <= 1'b0;

      // Capture and consume never collide: capture needs an empty slot.
      if (w_wr_edge && !r_wr_pend && write_len != 8'd0) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= write_addr;
        r_wr_len  <= write_len;
      end
      if (w_rd_edge && !r_rd_pend && read_len != 8'd0) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= read_addr;
        r_rd_len  <= read_len;
      end

      case (r_state)
        S_IDLE: begin
          if (r_wr_pend) begin
            r_wr_pend <= 1'b0;
            r_awaddr  <= r_wr_addr;
            r_awlen   <= r_wr_len - 8'd1;
            r_awvalid <= 1'b1;
            r_state   <= S_WR_ADDR;
          end else if (r_rd_pend) begin
            r_rd_pend <= 1'b0;
            r_araddr  <= r_rd_addr;
            r_arlen   <= r_rd_len - 8'd1;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (axi_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (r_awlen == 8'd0);
            r_beat    <= '0;
            r_state   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (axi_wready) begin
            r_beat <= r_beat + 8'd1;
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_WR_RESP;
            end else begin
              r_wlast <= (r_beat + 8'd1 == r_awlen);
            end
          end
        end
        S_WR_RESP: begin
          if (axi_bvalid) begin
            r_resp       <= axi_bresp;
            r_bready     <= 1'b0;
            r_write_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi_rvalid) begin
            r_read_data       <= axi_rdata;
            r_read_data_valid <= 1'b1;
            if (axi_rlast) begin
              r_rready    <= 1'b0;
              r_read_done <= 1'b1;
              r_resp      <= 2'b00;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ack is taken straight from the W handshake so the requester can present
  // the next beat on the following cycle.
  assign write_data_ack  = r_wvalid & axi_wready;
  assign axi_wdata       = r_wvalid ? write_data : '0;
  assign axi_wvalid      = r_wvalid;
  assign axi_wlast       = r_wlast;
  assign axi_awaddr      = r_awaddr;
  assign axi_awlen       = r_awlen;
  assign axi_awsize      = r_awvalid ? AXSIZE : 3'd0;
  assign axi_awburst     = r_awvalid ? BURST_INCR : 2'b00;
  assign axi_awvalid     = r_awvalid;
  assign axi_bready      = r_bready;
  assign axi_araddr      = r_araddr;
  assign axi_arlen       = r_arlen;
  assign axi_arsize      = r_arvalid ? AXSIZE : 3'd0;
  assign axi_arburst     = r_arvalid ? BURST_INCR : 2'b00;
  assign axi_arvalid     = r_arvalid;
  assign axi_rready      = r_rready;
  assign read_data       = r_read_data;
  assign read_data_valid = r_read_data_valid;
  assign write_done      = r_write_done;
  assign read_done       = r_read_done;
  assign resp            = r_resp;
  assign busy            = (r_state != S_IDLE) || r_wr_pend || r_rd_pend;

endmodule

// File: tb/tb_axi4_memory_controller.sv
// Directed bench for axi4_memory_controller: scoreboarded AW/W/AR/read-data
// expectations, a simple responsive slave and a write-data requester model.
module tb_axi4_memory_controller;

  localparam logic [31:0] RBASE = 32'hA000_0000;

  logic        clk;
  logic        reset_n;
  logic        start_write, start_read;
  logic [31:0] write_addr, read_addr, write_data, read_data;
  logic [7:0]  write_len, read_len;
  logic        write_data_ack, read_data_valid, write_done, read_done, busy;
  logic [1:0]  resp;
  logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
  logic [7:0]  axi_awlen, axi_arlen;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rlast, axi_rvalid, axi_rready;

  axi4_memory_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_write(start_write), .write_addr(write_addr), .write_len(write_len),
    .write_data(write_data), .write_data_ack(write_data_ack),
    .start_read(start_read), .read_addr(read_addr), .read_len(read_len),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .write_done(write_done), .read_done(read_done), .resp(resp), .busy(busy),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  ax_t         aw_q[$], ar_q[$];
  w_t          w_q[$];
  logic [31:0] r_q[$];

  int    n_checks = 0, n_err = 0;
  int    aw_hs = 0, ar_hs = 0, ack_cnt = 0, wdone_cnt = 0, rdone_cnt = 0, r_beats = 0;
  int    w_idx = 0, rd_cfg_len = 1;
  logic  [31:0] w_base = '0;
  bit    adv_pending = 0, aw_accepted = 0, wready_toggle = 0, rd_burst_mode = 0;
  string ev = "";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  // Monitor samples 1 ns before each rising edge, when handshakes are settled.
  always @(negedge clk) begin
    #4;
    if (reset_n == 1'b0) begin
      if (axi_awvalid && !axi_awready && aw_q.size() > 0) begin
        check("aw_stall_addr", 64'(axi_awaddr), 64'(aw_q[0].addr));
        check("aw_stall_len", 64'(axi_awlen), 64'(aw_q[0].len));
      end
      if (axi_awvalid && axi_awready) begin
        ax_t e;
        ev = {ev, "a"};
        aw_hs++;
        aw_accepted = 1;
        if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          e = aw_q.pop_front();
          check("awaddr", 64'(axi_awaddr), 64'(e.addr));
          check("awlen", 64'(axi_awlen), 64'(e.len));
          check("awsize", 64'(axi_awsize), 64'd2);
          check("awburst", 64'(axi_awburst), 64'd1);
        end
      end
      if (axi_wvalid && axi_wready) begin
        w_t e;
        check("w_after_aw", 64'(aw_accepted), 64'd1);
        if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          e = w_q.pop_front();
          check("wdata", 64'(axi_wdata), 64'(e.data));
          check("wlast", 64'(axi_wlast), 64'(e.last));
        end
      end
      if (write_data_ack) begin
        ack_cnt++;
        adv_pending = 1;
      end
      if (axi_bvalid && axi_bready) aw_accepted = 0;
      if (write_done) begin
        ev = {ev, "W"};
        wdone_cnt++;
      end
      if (axi_arvalid && axi_arready) begin
        ax_t e;
        ev = {ev, "r"};
        ar_hs++;
        if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
        else begin
          e = ar_q.pop_front();
          check("araddr", 64'(axi_araddr), 64'(e.addr));
          check("arlen", 64'(axi_arlen), 64'(e.len));
          check("arsize", 64'(axi_arsize), 64'd2);
          check("arburst", 64'(axi_arburst), 64'd1);
        end
      end
      if (axi_rvalid && axi_rready) r_beats++;
      if (read_data_valid) begin
        if (r_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("read_data", 64'(read_data), 64'(r_q.pop_front()));
      end
      if (read_done) begin
        ev = {ev, "R"};
        rdone_cnt++;
      end
    end
  end

  // Requester presents the next write beat after each ack; slave drives W/R.
  always @(negedge clk) begin
    if (adv_pending) begin
      adv_pending = 0;
      w_idx++;
      write_data = w_base + 32'(w_idx);
    end
    if (wready_toggle) axi_wready = ~axi_wready;
    if (rd_burst_mode) begin
      axi_rdata = RBASE + 32'(r_beats);
      axi_rlast = (r_beats == rd_cfg_len - 1);
    end
  end

  task automatic expect_wr(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base);
    ax_t a;
    w_t  w;
    a.addr = addr;
    a.len  = len - 8'd1;
    aw_q.push_back(a);
    for (int i = 0; i < int'(len); i++) begin
      w.data = base + 32'(i);
      w.last = (i == int'(len) - 1);
      w_q.push_back(w);
    end
  endtask

  task automatic expect_rd(input logic [31:0] addr, input logic [7:0] len, input bit burst);
    ax_t a;
    a.addr = addr;
    a.len  = len - 8'd1;
    ar_q.push_back(a);
    if (burst) for (int i = 0; i < int'(len); i++) r_q.push_back(RBASE + 32'(i));
    else r_q.push_back(32'h1234_5678);
  endtask

  task automatic start_wr(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base);
    expect_wr(addr, len, base);
    @(negedge clk);
    write_addr = addr; write_len = len;
    w_base = base; w_idx = 0; write_data = base;
    start_write = 1;
    @(negedge clk);
    start_write = 0;
  endtask

  task automatic start_rd(input logic [31:0] addr, input logic [7:0] len, input bit burst);
    expect_rd(addr, len, burst);
    @(negedge clk);
    read_addr = addr; read_len = len; r_beats = 0;
    start_read = 1;
    @(negedge clk);
    start_read = 0;
  endtask

  task automatic wait_done(input int wt, input int rt, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wdone_cnt >= wt && rdone_cnt >= rt) break;
    end
    check({tag, "_done"}, 64'(wdone_cnt >= wt && rdone_cnt >= rt), 64'd1);
  endtask

  task automatic wait_wvalid(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi_wvalid) break;
    end
    check(tag, 64'(axi_wvalid), 64'd1);
  endtask

  initial begin
    int aw_before, ar_before;
    reset_n = 1; start_write = 0; start_read = 0;
    write_addr = '0; write_len = '0; write_data = '0;
    read_addr = '0; read_len = '0;
    axi_awready = 1; axi_wready = 1; axi_bresp = 2'b00; axi_bvalid = 1;
    axi_arready = 1; axi_rdata = 32'h1234_5678; axi_rlast = 1; axi_rvalid = 1;
    repeat (3) @(negedge clk);

    check("rst_awvalid", 64'(axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(axi_wvalid), 64'd0);
    check("rst_bready", 64'(axi_bready), 64'd0);
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_rready", 64'(axi_rready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_rdv", 64'(read_data_valid), 64'd0);
    check("rst_dones", 64'({write_done, read_done}), 64'd0);
    reset_n = 0;
    repeat (2) @(negedge clk);

    // Basic write burst
    ack_cnt = 0;
    start_wr(32'h0, 8'd4, 32'h100);
    wait_done(1, 0, "wr1");
    check("wr1_resp", 64'(resp), 64'd0);
    check("wr1_acks", 64'(ack_cnt), 64'd4);
    check("wr1_wq_empty", 64'(w_q.size()), 64'd0);
    @(negedge clk);
    check("wr1_busy", 64'(busy), 64'd0);

    // Read with constant rlast: single beat
    start_rd(32'h0, 8'd4, 0);
    wait_done(1, 1, "rd1");
    @(negedge clk);
    check("rd1_busy", 64'(busy), 64'd0);
    check("rd1_rq_empty", 64'(r_q.size()), 64'd0);

    // Multi-beat read with slave-generated data and rlast
    rd_burst_mode = 1; rd_cfg_len = 3;
    start_rd(32'h2000, 8'd3, 1);
    wait_done(1, 2, "rd2");
    check("rd2_rq_empty", 64'(r_q.size()), 64'd0);
    rd_burst_mode = 0; axi_rlast = 1; axi_rdata = 32'h1234_5678;

    // Backpressure on AW and toggling W ready
    ack_cnt = 0;
    axi_awready = 0;
    start_wr(32'h40, 8'd4, 32'h200);
    repeat (5) @(negedge clk);
    check("bp_no_w_yet", 64'(axi_wvalid), 64'd0);
    axi_awready = 1; wready_toggle = 1;
    wait_done(2, 2, "bp");
    check("bp_acks", 64'(ack_cnt), 64'd4);
    wready_toggle = 0; axi_wready = 1;

    // Read request queued behind a write; start_write held ~10 cycles
    ev = ""; aw_before = aw_hs;
    expect_wr(32'h400, 8'd4, 32'h500);
    expect_rd(32'h600, 8'd2, 0);
    @(negedge clk);
    write_addr = 32'h400; write_len = 8'd4;
    w_base = 32'h500; w_idx = 0; write_data = 32'h500;
    read_addr = 32'h600; read_len = 8'd2;
    start_write = 1;
    wait_wvalid("q_wvalid");
    start_read = 1;
    @(negedge clk);
    start_read = 0;
    repeat (6) @(negedge clk);
    start_write = 0;
    wait_done(3, 3, "queued");
    check_str("queued_order", ev, "aWrR");
    check("queued_one_aw", 64'(aw_hs - aw_before), 64'd1);

    // Simultaneous start edges: write wins
    ev = "";
    expect_wr(32'h800, 8'd2, 32'h700);
    expect_rd(32'h900, 8'd1, 0);
    @(negedge clk);
    write_addr = 32'h800; write_len = 8'd2;
    w_base = 32'h700; w_idx = 0; write_data = 32'h700;
    read_addr = 32'h900; read_len = 8'd1;
    start_write = 1; start_read = 1;
    @(negedge clk);
    start_write = 0; start_read = 0;
    wait_done(4, 4, "simul");
    check_str("simul_order", ev, "aWrR");

    // Zero-length request is dropped
    aw_before = aw_hs;
    @(negedge clk);
    write_addr = 32'hC00; write_len = 8'd0; start_write = 1;
    @(negedge clk);
    start_write = 0;
    repeat (10) @(negedge clk);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_no_aw", 64'(aw_hs - aw_before), 64'd0);

    // Reset in WR_DATA with a read pending
    axi_wready = 0; ar_before = ar_hs;
    start_wr(32'h80, 8'd8, 32'h900);
    wait_wvalid("rst_mid_wvalid");
    read_addr = 32'hA00; read_len = 8'd2; start_read = 1;
    @(negedge clk);
    start_read = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    check("mid_rst_awvalid", 64'(axi_awvalid), 64'd0);
    check("mid_rst_wvalid", 64'(axi_wvalid), 64'd0);
    check("mid_rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("mid_rst_bready", 64'(axi_bready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    w_q.delete(); aw_accepted = 0; adv_pending = 0;
    @(negedge clk);
    reset_n = 0; axi_wready = 1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_no_ar", 64'(ar_hs - ar_before), 64'd0);

    // SLVERR write response is latched, then a read clears resp
    axi_bresp = 2'b10;
    start_wr(32'h10, 8'd1, 32'hABC);
    wait_done(5, 4, "slverr");
    check("slverr_resp", 64'(resp), 64'd2);
    axi_bresp = 2'b00;
    start_rd(32'h20, 8'd1, 0);
    wait_done(5, 5, "rd_after_err");
    check("rd_resp", 64'(resp), 64'd0);
    check("end_queues", 64'(aw_q.size() + ar_q.size() + w_q.size() + r_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
